// File: rtl/csr_unit_pkg.sv
// Shared CSR definitions for csr_unit: operation codes and the fixed CSR address map.
package csr_unit_pkg;

   // Encoding follows funct3 so the decoder can pass it through; RSV (funct3=100) is never legal.
   typedef enum logic [2:0] {
      NA       = 3'd0,
      CSRRW    = 3'd1,
      CSRRS    = 3'd2,
      CSRRC    = 3'd3,
      CSRR_RSV = 3'd4,
      CSRRWI   = 3'd5,
      CSRRSI   = 3'd6,
      CSRRCI   = 3'd7
   } CsrOp_t;

   localparam logic [11:0] CSR_CYCLE     = 12'hC00;
   localparam logic [11:0] CSR_TIME      = 12'hC01;
   localparam logic [11:0] CSR_INSTRET   = 12'hC02;
   localparam logic [11:0] CSR_CYCLEH    = 12'hC80;
   localparam logic [11:0] CSR_TIMEH     = 12'hC81;
   localparam logic [11:0] CSR_INSTRETH  = 12'hC82;
   localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
   localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
   localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
   localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
   localparam logic [11:0] CSR_MSCRATCH  = 12'h340;

   function automatic logic csr_is_imm(input CsrOp_t op);
      return (op == CSRRWI) || (op == CSRRSI) || (op == CSRRCI);
   endfunction

endpackage

// File: rtl/csr_counter64.sv
// 64-bit free-running counter with independent low/high half write ports.
module csr_counter64 (
   input  logic        clk,
   input  logic        rst,
   input  logic        inc,
   input  logic        wr_lo,
   input  logic        wr_hi,
   input  logic [31:0] wdata,
   output logic [63:0] count
);

   logic [32:0] lo_sum;

   assign lo_sum = {1'b0, count[31:0]} + {32'd0, inc};

   // A half write wins over the increment for that half; the carry across halves is dropped.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
      end else if (wr_lo) begin
         count[31:0] <= wdata;
      end else if (wr_hi) begin
         count <= {wdata, lo_sum[31:0]};
      end else begin
         count <= {count[63:32] + {31'd0, lo_sum[32]}, lo_sum[31:0]};
      end
   end

endmodule

// File: rtl/csr_unit.sv
// CSR responder: combinational old-value read, single clocked read-modify-write update.
// Optional feature macro CSR_INSTRET_EN adds the instret counter and its four addresses.
module csr_unit
   import csr_unit_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        csr_en,
   input  CsrOp_t      csr_op,
   input  logic [11:0] csr_addr,
   input  logic [4:0]  rs1_idx,
   input  logic [31:0] rs1_data,
   input  logic        instret_inc,
   output logic [31:0] rdata,
   output logic        illegal
);

   logic [63:0] cycle_q;
   logic [31:0] mscratch_q;
   logic [31:0] old_val;
   logic [31:0] src;
   logic [31:0] new_val;
   logic        mapped;
   logic        op_ok;
   logic        wr_req;
   logic        we;

`ifdef CSR_INSTRET_EN
   logic [63:0] instret_q;
   logic        ins_wr_lo;
   logic        ins_wr_hi;
`else
   logic        unused_instret_inc;
   assign unused_instret_inc = instret_inc;
`endif

   always_comb begin
      mapped  = 1'b1;
      old_val = 32'd0;
      case (csr_addr)
         CSR_CYCLE, CSR_TIME, CSR_MCYCLE:    old_val = cycle_q[31:0];
         CSR_CYCLEH, CSR_TIMEH, CSR_MCYCLEH: old_val = cycle_q[63:32];
         CSR_MSCRATCH:                       old_val = mscratch_q;
`ifdef CSR_INSTRET_EN
         CSR_INSTRET, CSR_MINSTRET:          old_val = instret_q[31:0];
         CSR_INSTRETH, CSR_MINSTRETH:        old_val = instret_q[63:32];
`endif
         default:                            mapped  = 1'b0;
      endcase
   end

   assign src = csr_is_imm(csr_op) ? {27'd0, rs1_idx} : rs1_data;

   always_comb begin
      op_ok   = 1'b1;
      new_val = old_val;
      case (csr_op)
         CSRRW, CSRRWI: new_val = src;
         CSRRS, CSRRSI: new_val = old_val | src;
         CSRRC, CSRRCI: new_val = old_val & ~src;
         default:       op_ok   = 1'b0;
      endcase
   end

   // Set/clear with x0/zimm=0 is a pure read, which keeps read-only CSRs readable via CSRRS.
   assign wr_req  = (csr_op == CSRRW) || (csr_op == CSRRWI) || (rs1_idx != 5'd0);
   assign illegal = csr_en && (!op_ok || !mapped || (wr_req && (csr_addr[11:10] == 2'b11)));
   assign rdata   = illegal ? 32'd0 : old_val;
   assign we      = csr_en && !illegal && wr_req;

   csr_counter64 u_cycle (
      .clk   (clk),
      .rst   (rst),
      .inc   (1'b1),
      .wr_lo (we && (csr_addr == CSR_MCYCLE)),
      .wr_hi (we && (csr_addr == CSR_MCYCLEH)),
      .wdata (new_val),
      .count (cycle_q)
   );

`ifdef CSR_INSTRET_EN
   assign ins_wr_lo = we && (csr_addr == CSR_MINSTRET);
   assign ins_wr_hi = we && (csr_addr == CSR_MINSTRETH);

   // An instruction writing minstret(h) does not count itself.
   csr_counter64 u_instret (
      .clk   (clk),
      .rst   (rst),
      .inc   (instret_inc && !(ins_wr_lo || ins_wr_hi)),
      .wr_lo (ins_wr_lo),
      .wr_hi (ins_wr_hi),
      .wdata (new_val),
      .count (instret_q)
   );
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mscratch_q <= 32'd0;
      end else if (we && (csr_addr == CSR_MSCRATCH)) begin
         mscratch_q <= new_val;
      end
   end

endmodule
